mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store memory interface directly downstream of the multicycle control FSM.
- FSM memory-write/read states issue a `start` pulse with address, store data and funct3. This block:
  - performs byte/halfword/word lane alignment;
  - drives a word-addressed memory over a req/ready handshake;
  - returns sign- or zero-extended load data with a one-cycle `done` pulse.
- The control FSM holds in its memory state while `busy` is high.

Parameters:
- TIMEOUT, 8'd255, REQ cycles without mem_ready before the transaction is aborted with `timeout`.
- CNT_W, 8, width of the timeout counter; TIMEOUT must fit in CNT_W bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request from control FSM; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V size/sign field (000 b, 001 h, 010 w, 100 bu, 101 hu).
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse, also asserted on error.
- rdata  out  32  extended load result, registered.
- misaligned  out  1  high with done when the access was rejected for alignment or illegal funct3.
- timeout  out  1  high with done when the memory failed to respond.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable, qualified by mem_req.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wmask  out  4  byte-lane write mask; 0000 for loads.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- mem_rdata  in  32  read word; valid in the cycle mem_req && mem_ready.

Behaviour:
- Reset values:
  - State IDLE; timeout counter 0.
  - All outputs 0, including rdata.
  - Reset mid-transaction drops mem_req immediately (asynchronous) and discards the access.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - On start, latch we, funct3, addr, wdata.
  - Illegal: funct3[1:0] == 11; store with funct3[2] == 1; half with addr[0] != 0; word with addr[1:0] != 00.
  - Illegal access -> ERR. Otherwise -> REQ.
  - start while not IDLE is ignored.
- REQ:
  - mem_req = 1. mem_addr, mem_we, mem_wmask, mem_wdata are stable from latched values for the whole state.
  - Handshake completes in the cycle mem_req && mem_ready -> DONE.
  - Otherwise increment the counter. When the counter == TIMEOUT-1 with no mem_ready -> ERR with the timeout cause.
- DONE: done = 1 for one cycle -> IDLE; counter cleared.
- ERR:
  - done = 1 and exactly one of misaligned / timeout = 1, for one cycle -> IDLE.
  - No mem_req is ever issued for a misaligned access.
- Write lanes (off = addr[1:0]):
  - sb: mask 0001<<off, data {4{wdata[7:0]}}.
  - sh: mask 0011<<off, data {2{wdata[15:0]}}.
  - sw: mask 1111, data wdata.
- Load extraction, registered into rdata at handshake:
  - lb: sign-extend mem_rdata byte at off; lbu: zero-extend.
  - lh: sign-extend half at off[1]; lhu: zero-extend.
  - lw: word.
- rdata holds its value through stores, errors and idle; it is updated only on a successful load.
- Latency with mem_ready tied high: start in cycle 0, REQ in cycle 1 (handshake), done in cycle 2. Each wait cycle adds one.
- mem_ready outside REQ is ignored.

Test Plan:
1. Reset, then lw at addr 0x100, mem_ready high, mem_rdata 0xDEADBEEF -> mem_addr 0x100, mem_wmask 0000, done in cycle 2, rdata 0xDEADBEEF, busy high in cycles 1-2.
2. lb at 0x103, then lbu at 0x103, mem_rdata 0x80FF_0000 -> rdata 0xFFFFFF80 then 0x00000080. lh at 0x102 -> 0xFFFF80FF.
3. sb at 0x201 with wdata 0x1234_56AB -> mem_wmask 0010, mem_wdata 0xABABABAB, mem_we 1. Also sh at 0x202 -> mask 1100, data 0x56AB56AB. rdata unchanged.
4. Misaligned: sw at 0x302 and lh at 0x301 -> no mem_req, done and misaligned in cycle 1. funct3 = 011 -> same.
5. mem_ready held low for 3 cycles then high -> mem_req continuously high 4 cycles, done 1 cycle later. With TIMEOUT = 4 and mem_ready never high -> done+timeout after 4 REQ cycles, mem_req drops.
6. rst asserted mid-REQ -> mem_req/busy low immediately. A second start pulse during REQ is ignored; next start after reset completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the multicycle control FSM and a word-addressed memory.
// Aligns byte/half/word lanes, runs the req/ready handshake and extends load data.
module mem_access_unit #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = TIMEOUT - 1'b1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic             illegal;

  // Size encodings 11 do not exist; unsigned variants only make sense for loads.
  function automatic logic illegal_access(input logic       w,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    if (w && f3[2]) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign illegal = illegal_access(we, funct3, addr[1:0]);

  // NOTE: every register here, outputs included, uses non-blocking assignment
  // and the asynchronous reset, so rst drops mem_req without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 32'd0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wmask  <= 4'b0000;
      mem_wdata  <= 32'd0;
    end else begin
      // NOTE: pulse outputs default low each cycle; a state sets them for one cycle.
      done       <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            we_q     <= we;
            funct3_q <= funct3;
            off_q    <= addr[1:0];
            busy     <= 1'b1;
            cnt      <= '0;
            if (illegal) begin
              state      <= ERR;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wmask <= we ? lane_mask(funct3, addr[1:0]) : 4'b0000;
              mem_wdata <= we ? lane_data(funct3, wdata) : 32'd0;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            state     <= DONE;
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'b0000;
            if (!we_q) rdata <= load_extract(funct3_q, off_q, mem_rdata);
          end else if (cnt == TMO_LAST) begin
            state     <= ERR;
            done      <= 1'b1;
            timeout   <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'b0000;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard of load
// results, and hand-written reset/ignored-start sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, misaligned, timeout;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.CNT_W(8), .TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst), .start(start), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .timeout(timeout), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          wait_n;
    logic [31:0] e_rdata;
    logic        e_mis;
    logic        e_tmo;
    int          e_done;
    int          e_reqs;
    logic [31:0] e_maddr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int wn,
                              input logic [31:0] er, input logic em, input logic et,
                              input int ed, input int eq, input logic [31:0] ema,
                              input logic [3:0] emk, input logic [31:0] ewd);
    vec_t v;
    v.we = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.rd = rd; v.wait_n = wn;
    v.e_rdata = er; v.e_mis = em; v.e_tmo = et; v.e_done = ed; v.e_reqs = eq;
    v.e_maddr = ema; v.e_mask = emk; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int   done_at = -1;
    int   reqs = 0;
    int   field_bad = 0;
    int   busy_bad = 0;
    exp_t e;
    @(negedge clk);
    start = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    mem_rdata = v.rd;
    mem_ready = 1'b1;  // asserted while still IDLE; must be ignored there
    e.rdata = v.e_rdata; e.mis = v.e_mis; e.tmo = v.e_tmo;
    sb_q.push_back(e);
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      if (mem_req === 1'b1) begin
        reqs++;
        if (mem_addr !== v.e_maddr || mem_we !== v.we || mem_wmask !== v.e_mask ||
            mem_wdata !== v.e_wdata) field_bad++;
      end
      mem_ready = (reqs > v.wait_n);
      if (done === 1'b1) begin
        done_at = c;
        if (sb_q.size() == 0) begin
          check({tag, " scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check({tag, " rdata"}, rdata, e.rdata);
          check({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
          check({tag, " timeout"}, {31'd0, timeout}, {31'd0, e.tmo});
        end
      end
    end
    check({tag, " done_cycle"}, done_at, v.e_done);
    check({tag, " req_cycles"}, reqs, v.e_reqs);
    check({tag, " mem_fields"}, field_bad, 0);
    check({tag, " busy_during"}, busy_bad, 0);
    @(negedge clk);
    check({tag, " after_pulse"}, {29'd0, done, busy, mem_req}, 32'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    // we f3 addr wdata mem_rdata wait | rdata mis tmo done reqs maddr mask wdata
    vecs[0]  = mk(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 2, 1, 32'h100, 4'b0000, 0);
    vecs[1]  = mk(0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, 32'hFFFFFF80, 0, 0, 2, 1, 32'h100, 4'b0000, 0);
    vecs[2]  = mk(0, 3'b100, 32'h103, 0, 32'h80FF0000, 0, 32'h00000080, 0, 0, 2, 1, 32'h100, 4'b0000, 0);
    vecs[3]  = mk(0, 3'b001, 32'h102, 0, 32'h80FF0000, 0, 32'hFFFF80FF, 0, 0, 2, 1, 32'h100, 4'b0000, 0);
    vecs[4]  = mk(0, 3'b101, 32'h102, 0, 32'h80FF0000, 0, 32'h000080FF, 0, 0, 2, 1, 32'h100, 4'b0000, 0);
    vecs[5]  = mk(1, 3'b000, 32'h201, 32'h123456AB, 32'hFFFFFFFF, 0, 32'h000080FF, 0, 0, 2, 1, 32'h200, 4'b0010, 32'hABABABAB);
    vecs[6]  = mk(1, 3'b001, 32'h202, 32'h123456AB, 32'hFFFFFFFF, 0, 32'h000080FF, 0, 0, 2, 1, 32'h200, 4'b1100, 32'h56AB56AB);
    vecs[7]  = mk(1, 3'b010, 32'h304, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 32'h000080FF, 0, 0, 2, 1, 32'h304, 4'b1111, 32'hCAFEF00D);
    vecs[8]  = mk(1, 3'b010, 32'h302, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 32'h000080FF, 1, 0, 1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 3'b001, 32'h301, 0, 32'hFFFFFFFF, 0, 32'h000080FF, 1, 0, 1, 0, 0, 0, 0);
    vecs[10] = mk(0, 3'b011, 32'h100, 0, 32'hFFFFFFFF, 0, 32'h000080FF, 1, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk(1, 3'b100, 32'h200, 32'h11, 32'hFFFFFFFF, 0, 32'h000080FF, 1, 0, 1, 0, 0, 0, 0);
    vecs[12] = mk(0, 3'b010, 32'h400, 0, 32'h01234567, 3, 32'h01234567, 0, 0, 5, 4, 32'h400, 4'b0000, 0);
    vecs[13] = mk(0, 3'b010, 32'h404, 0, 32'hFFFFFFFF, 99, 32'h01234567, 0, 1, 5, 4, 32'h404, 4'b0000, 0);
    vecs[14] = mk(0, 3'b000, 32'h500, 0, 32'h0000007F, 0, 32'h0000007F, 0, 0, 2, 1, 32'h500, 4'b0000, 0);
    vecs[15] = mk(0, 3'b000, 32'h501, 0, 32'h0000FE00, 0, 32'hFFFFFFFE, 0, 0, 2, 1, 32'h500, 4'b0000, 0);
    vecs[16] = mk(1, 3'b001, 32'h200, 32'h0000BEEF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 0, 0, 3, 2, 32'h200, 4'b0011, 32'hBEEFBEEF);
    vecs[17] = mk(0, 3'b100, 32'h502, 0, 32'h00AB0000, 2, 32'h000000AB, 0, 0, 4, 3, 32'h500, 4'b0000, 0);

    #12;
    check("reset_outputs",
          {busy, done, misaligned, timeout, mem_req, mem_we, mem_wmask, 2'b00},
          32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset mid-REQ with an ignored second start.
    @(negedge clk);
    start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h600; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("midreq mem_req", {31'd0, mem_req}, 32'd1);
    start = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h700;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start addr", mem_addr, 32'h600);
    check("ignored_start we", {31'd0, mem_we}, 32'd0);
    check("ignored_start req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst req_busy", {30'd0, mem_req, busy}, 32'd0);
    check("async_rst rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(0, 3'b010, 32'h100, 0, 32'h11223344, 0, 32'h11223344, 0, 0, 2, 1, 32'h100, 4'b0000, 0),
            "post_rst");

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
